// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types and helpers for the time-multiplexed FIR MAC engine
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fir_state_e;

  // Worst-case sum of NTAPS signed x zero-extended products needs log2(NTAPS) guard bits.
  function automatic int fir_acc_width(int cw, int dw, int ntaps);
    return cw + dw + 1 + $clog2(ntaps);
  endfunction

  // Keeps DW bits just below the raw word's MSB: raw[in_w-2 -: dw].
  function automatic logic [63:0] fir_slice_sample(logic [63:0] raw, int in_w, int dw);
    logic [63:0] mask;
    mask = (64'd1 << dw) - 64'd1;
    return (raw >> (in_w - 1 - dw)) & mask;
  endfunction

endpackage

// File: rtl/fir_mac_datapath.sv
// rtl/fir_mac_datapath.sv - registered signed x unsigned multiplier feeding an AW-bit accumulator
module fir_mac_datapath
  import fir_pkg::*;
#(
  parameter int CW = 16,
  parameter int DW = 16,
  parameter int AW = fir_acc_width(16, 16, 4)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 prod_clr_i,
  input  logic                 mul_en_i,
  input  logic                 acc_en_i,
  input  logic                 acc_clr_i,
  input  logic signed [CW-1:0] coef_i,
  input  logic        [DW-1:0] sample_i,
  output logic signed [AW-1:0] acc_o
);

  localparam int PW = CW + DW + 1;

  logic signed [PW-1:0] prod_q, prod_d;
  logic signed [AW-1:0] acc_q, acc_d;

  always_comb begin
    prod_d = prod_q;
    if (prod_clr_i) begin
      prod_d = '0;
    end else if (mul_en_i) begin
      prod_d = PW'(coef_i) * PW'($signed({1'b0, sample_i}));
    end
  end

  // The accumulator always consumes the product registered one cycle earlier.
  always_comb begin
    acc_d = acc_q;
    if (acc_clr_i) begin
      acc_d = '0;
    end else if (acc_en_i) begin
      acc_d = acc_q + AW'(prod_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      prod_q <= prod_d;
      acc_q  <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/fir_mac_engine.sv
// rtl/fir_mac_engine.sv - NTAPS-tap FIR core sharing one multiplier across taps
module fir_mac_engine
  import fir_pkg::*;
#(
  parameter int  NTAPS = 4,
  parameter int  IN_W  = 25,
  parameter int  DW    = 16,
  parameter int  CW    = 16,
  parameter int  AW    = fir_acc_width(CW, DW, NTAPS),
  localparam int IW    = $clog2(NTAPS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sample_valid_i,
  input  logic [IN_W-1:0]      sample_i,
  output logic                 sample_ready_o,
  input  logic                 coef_we_i,
  input  logic [IW-1:0]        coef_idx_i,
  input  logic signed [CW-1:0] coef_data_i,
  output logic signed [AW-1:0] y_o,
  output logic                 y_valid_o,
  output logic                 busy_o,
  output logic                 overrun_o
);

  fir_state_e           state_q;
  logic [IW-1:0]        k_q;
  logic [DW-1:0]        win_q  [NTAPS];
  logic signed [CW-1:0] coef_q [NTAPS];
  logic signed [AW-1:0] y_q;
  logic                 y_valid_q;
  logic                 overrun_q;

  logic [DW-1:0]        sample_d;
  logic                 accept_d;
  logic                 coef_wr_d;
  logic signed [AW-1:0] acc_d;

  assign sample_d  = DW'(fir_slice_sample(64'(sample_i), IN_W, DW));
  assign accept_d  = (state_q == IDLE) && sample_valid_i;
  assign coef_wr_d = (state_q == IDLE) && coef_we_i && (32'(coef_idx_i) < NTAPS);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        win_q[i]  <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      y_valid_q <= 1'b0;
      if (sample_valid_i && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
      if (coef_wr_d) begin
        coef_q[coef_idx_i] <= coef_data_i;
      end
      case (state_q)
        IDLE: begin
          if (sample_valid_i) begin
            win_q[0] <= sample_d;
            for (int i = 1; i < NTAPS; i++) begin
              win_q[i] <= win_q[i-1];
            end
            k_q     <= '0;
            state_q <= MAC;
          end
        end
        MAC: begin
          k_q <= k_q + IW'(1);
          if (k_q == IW'(NTAPS - 1)) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: state_q <= DONE;
        DONE: begin
          y_q       <= acc_d;
          y_valid_q <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Product register is cleared on accept so the first MAC cycle accumulates zero.
  fir_mac_datapath #(
    .CW(CW),
    .DW(DW),
    .AW(AW)
  ) u_datapath (
    .clk       (clk),
    .reset_n   (reset_n),
    .prod_clr_i(accept_d),
    .mul_en_i  (state_q == MAC),
    .acc_en_i  ((state_q == MAC) || (state_q == DRAIN)),
    .acc_clr_i (accept_d || (state_q == DONE)),
    .coef_i    (coef_q[k_q]),
    .sample_i  (win_q[k_q]),
    .acc_o     (acc_d)
  );

  assign y_o            = y_q;
  assign y_valid_o      = y_valid_q;
  assign overrun_o      = overrun_q;
  assign sample_ready_o = (state_q == IDLE);
  assign busy_o         = (state_q != IDLE);

endmodule
